alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_bit_slice.sv | 38 +++
 rtl/alu_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes, FSM state
// encoding, default operand width and small op-classification helpers.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Op codes presented on the op port.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Sequencer state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True for the five codes the datapath implements.
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True for ops computed as a + ~b + 1 (inverted b, carry-in of 1).
    function automatic logic op_uses_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // True for ops whose carry/overflow flags are reported.
    function automatic logic op_is_addsub(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: logic ops or a full-adder bit, depending on op.
// Any b inversion for subtraction is done by the caller.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       ci,
    input  logic [2:0] op,
    output logic       r,
    output logic       co
);

    // Combinational bit result and carry-out for the selected op.
    always_comb begin
        r  = 1'b0;
        co = 1'b0;
        case (op)
            OP_AND: begin
                r  = a & b;
                co = 1'b0;
            end
            OP_OR: begin
                r  = a | b;
                co = 1'b0;
            end
            OP_ADD, OP_SUB, OP_SLT: begin
                r  = a ^ b ^ ci;
                co = (a & b) | (a & ci) | (b & ci);
            end
            default: begin
                r  = 1'b0;
                co = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Bit-serial ALU controller. A legal start latches the operands and walks a
// single alu_bit_slice across them LSB first, one bit per RUN cycle, then
// raises done for one cycle with the result and flags held afterwards.
// Illegal op codes skip RUN and report err directly.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             cy_r, cy_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [2:0]       op_r, op_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic [WIDTH-1:0] fin_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             zero_r, zero_s;
    logic             carry_r, carry_s;
    logic             ovf_r, ovf_s;
    logic             err_r, err_s;

    logic             slice_a_s;
    logic             slice_b_s;
    logic             slice_r_s;
    logic             slice_co_s;

    assign slice_a_s = a_r[cnt_r];
    assign slice_b_s = op_uses_sub(op_r) ? ~b_r[cnt_r] : b_r[cnt_r];

    alu_bit_slice u_slice (
        .a  (slice_a_s),
        .b  (slice_b_s),
        .ci (cy_r),
        .op (op_r),
        .r  (slice_r_s),
        .co (slice_co_s)
    );

    // Next-state, datapath and flag computation for all three states.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        cy_s     = cy_r;
        a_s      = a_r;
        b_s      = b_r;
        op_s     = op_r;
        result_s = result_r;
        zero_s   = zero_r;
        carry_s  = carry_r;
        ovf_s    = ovf_r;
        err_s    = err_r;
        fin_s    = result_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (op_is_legal(op)) begin
                        state_s = ST_RUN;
                        a_s     = a;
                        b_s     = b;
                        op_s    = op;
                        cnt_s   = '0;
                        cy_s    = op_uses_sub(op);
                        err_s   = 1'b0;
                    end else begin
                        state_s  = ST_DONE;
                        result_s = '0;
                        zero_s   = 1'b0;
                        carry_s  = 1'b0;
                        ovf_s    = 1'b0;
                        err_s    = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                fin_s        = result_r;
                fin_s[cnt_r] = slice_r_s;
                cy_s         = slice_co_s;
                cnt_s        = cnt_r + CW'(1);
                if (cnt_r == LAST) begin
                    // MSB step: carry register holds the carry into the MSB.
                    state_s = ST_DONE;
                    cnt_s   = '0;
                    if (op_r == OP_SLT) begin
                        fin_s    = '0;
                        fin_s[0] = slice_r_s ^ (cy_r ^ slice_co_s);
                        carry_s  = 1'b0;
                        ovf_s    = 1'b0;
                    end else if (op_is_addsub(op_r)) begin
                        carry_s = slice_co_s;
                        ovf_s   = cy_r ^ slice_co_s;
                    end else begin
                        carry_s = 1'b0;
                        ovf_s   = 1'b0;
                    end
                    zero_s = (fin_s == '0);
                end else begin
                    state_s = ST_RUN;
                end
                result_s = fin_s;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
        busy_s = (state_s == ST_RUN);
        done_s = (state_s == ST_DONE);
    end

    // State and registered outputs; rst_n aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            cy_r     <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= OP_AND;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            zero_r   <= 1'b0;
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            cy_r     <= cy_s;
            a_r      <= a_s;
            b_r      <= b_s;
            op_r     <= op_s;
            result_r <= result_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            zero_r   <= zero_s;
            carry_r  <= carry_s;
            ovf_r    <= ovf_s;
            err_r    <= err_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign zero   = zero_r;
    assign carry  = carry_r;
    assign ovf    = ovf_r;
    assign err    = err_r;

endmodule
